// File: rtl/req_pending_if.sv
// Request/pending/grant bundle between the pending latch, its priority encoder and the grant consumer.
interface req_pending_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned W = 1 << N;

  logic [W-1:0] req;
  logic [W-1:0] pend;
  logic [N-1:0] enc_idx;
  logic         grant_valid;
  logic         grant_ready;
  logic [N-1:0] grant_idx;

  modport master (
    input  req,
    input  enc_idx,
    input  grant_ready,
    output pend,
    output grant_valid,
    output grant_idx
  );

  modport slave (
    output req,
    output enc_idx,
    output grant_ready,
    input  pend,
    input  grant_valid,
    input  grant_idx
  );
endinterface

// File: rtl/req_pending_latch.sv
// Sticky request capture ahead of an external MSB-first priority encoder; issues the encoded
// index as a valid/ready grant, clears the granted bit and counts requests lost to overrun.
module req_pending_latch #(
  parameter int unsigned N     = 3,
  parameter int unsigned OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  req_pending_if.master    bus,
  output logic [OVR_W-1:0] overrun_cnt_o
);
  localparam int unsigned W     = 1 << N;
  localparam int unsigned CNT_W = N + 1;
  localparam int unsigned SUM_W = OVR_W + CNT_W;
  localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};

  logic [W-1:0]     pend_q, pend_d;
  logic             gvalid_q, gvalid_d;
  logic [N-1:0]     gidx_q, gidx_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  logic             slot_free;
  logic             load;
  logic [W-1:0]     clr_mask;
  logic [W-1:0]     lost;
  logic [CNT_W-1:0] lost_cnt;
  logic [SUM_W-1:0] ovr_sum;

  // Grant path, pending update and saturating overrun accumulation
  always_comb begin
    slot_free = 1'b0;
    load      = 1'b0;
    clr_mask  = '0;
    lost      = '0;
    lost_cnt  = '0;
    ovr_sum   = '0;
    pend_d    = pend_q;
    gvalid_d  = gvalid_q;
    gidx_d    = gidx_q;
    ovr_d     = ovr_q;

    slot_free = !gvalid_q || bus.grant_ready;
    // enc_idx is meaningless for an empty vector, so gate on our own OR-reduce
    load      = slot_free && (|pend_q);
    if (load) begin
      clr_mask = W'(1) << bus.enc_idx;
    end

    // A request landing on the bit being granted re-arms it rather than being lost
    pend_d = (pend_q & ~clr_mask) | bus.req;
    lost   = bus.req & pend_q & ~clr_mask;

    for (int unsigned i = 0; i < W; i++) begin
      lost_cnt = lost_cnt + CNT_W'(lost[i]);
    end
    ovr_sum = SUM_W'(ovr_q) + SUM_W'(lost_cnt);
    ovr_d   = (ovr_sum > SUM_W'(OVR_MAX)) ? OVR_MAX : OVR_W'(ovr_sum);

    if (slot_free) begin
      gvalid_d = load;
      if (load) begin
        gidx_d = bus.enc_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      gvalid_q <= 1'b0;
      gidx_q   <= '0;
      ovr_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      gvalid_q <= gvalid_d;
      gidx_q   <= gidx_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.pend        = pend_q;
  assign bus.grant_valid = gvalid_q;
  assign bus.grant_idx   = gidx_q;
  assign overrun_cnt_o   = ovr_q;
endmodule

// File: tb/tb_req_pending_latch.sv
// Directed bench for req_pending_latch with a behavioural MSB-first encoder in the loop;
// a second instance with a 2-bit overrun counter exercises saturation.
module tb_req_pending_latch;
  logic clk;
  logic rst_n;
  logic [7:0] ovr0;
  logic [1:0] ovr1;
  int n_chk;
  int n_fail;

  req_pending_if #(.N(3)) if0 ();
  req_pending_if #(.N(3)) if1 ();

  req_pending_latch #(.N(3), .OVR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .overrun_cnt_o(ovr0)
  );

  req_pending_latch #(.N(3), .OVR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .overrun_cnt_o(ovr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] msb_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb if0.enc_idx = msb_idx(if0.pend);
  always_comb if1.enc_idx = msb_idx(if1.pend);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [7:0] pend, input logic gv,
                      input logic [2:0] gi, input logic [7:0] ovr);
    check({tag, ".pend"}, 32'(if0.pend), 32'(pend));
    check({tag, ".gv"},   32'(if0.grant_valid), 32'(gv));
    if (gv) check({tag, ".gi"}, 32'(if0.grant_idx), 32'(gi));
    check({tag, ".ovr"},  32'(ovr0), 32'(ovr));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    if0.req = '0; if0.grant_ready = 1'b1;
    if1.req = '0; if1.grant_ready = 1'b0;
    step(); step();
    chk0("rst_init", 8'h00, 1'b0, 3'd0, 8'd0);
    check("rst_init.gi", 32'(if0.grant_idx), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset mid-stream: two cycles of 8'hFF, then asynchronous assert
    if0.req = 8'hFF;
    step();
    chk0("ff1", 8'hFF, 1'b0, 3'd0, 8'd0);
    step();
    chk0("ff2", 8'hFF, 1'b1, 3'd7, 8'd7);
    rst_n = 1'b0;
    #1;
    chk0("rst_async", 8'h00, 1'b0, 3'd0, 8'd0);
    if0.req = '0;
    step();
    rst_n = 1'b1;
    step();
    chk0("rst_rel", 8'h00, 1'b0, 3'd0, 8'd0);

    // Single request with ready held high
    if0.req = 8'h04;
    step();
    chk0("one_p", 8'h04, 1'b0, 3'd0, 8'd0);
    if0.req = 8'h00;
    step();
    chk0("one_g", 8'h00, 1'b1, 3'd2, 8'd0);
    step();
    chk0("one_idle", 8'h00, 1'b0, 3'd0, 8'd0);

    // Priority drain of 8'hA1
    if0.req = 8'hA1;
    step();
    chk0("drn_p", 8'hA1, 1'b0, 3'd0, 8'd0);
    if0.req = 8'h00;
    step();
    chk0("drn7", 8'h21, 1'b1, 3'd7, 8'd0);
    step();
    chk0("drn5", 8'h01, 1'b1, 3'd5, 8'd0);
    step();
    chk0("drn0", 8'h00, 1'b1, 3'd0, 8'd0);
    step();
    chk0("drn_idle", 8'h00, 1'b0, 3'd0, 8'd0);

    // Backpressure with pending 8'h81
    if0.req = 8'h81;
    step();
    chk0("bp_p", 8'h81, 1'b0, 3'd0, 8'd0);
    if0.req = 8'h00;
    step();
    chk0("bp_g7", 8'h01, 1'b1, 3'd7, 8'd0);
    if0.grant_ready = 1'b0;
    step();
    chk0("bp_hold1", 8'h01, 1'b1, 3'd7, 8'd0);
    step();
    chk0("bp_hold2", 8'h01, 1'b1, 3'd7, 8'd0);
    if0.grant_ready = 1'b1;
    step();
    chk0("bp_g0", 8'h00, 1'b1, 3'd0, 8'd0);
    step();
    chk0("bp_idle", 8'h00, 1'b0, 3'd0, 8'd0);

    // Overrun while busy, then set-wins on the granted bit
    if0.grant_ready = 1'b0;
    if0.req = 8'h90;
    step();
    chk0("ov_p", 8'h90, 1'b0, 3'd0, 8'd0);
    if0.req = 8'h00;
    step();
    chk0("ov_busy", 8'h10, 1'b1, 3'd7, 8'd0);
    if0.req = 8'h10;
    step();
    chk0("ov_lost", 8'h10, 1'b1, 3'd7, 8'd1);
    if0.grant_ready = 1'b1;
    step();
    chk0("ov_setwin", 8'h10, 1'b1, 3'd4, 8'd1);
    if0.req = 8'h00;
    step();
    chk0("ov_regrant", 8'h00, 1'b1, 3'd4, 8'd1);
    step();
    chk0("ov_idle", 8'h00, 1'b0, 3'd0, 8'd1);

    // Saturation on the 2-bit counter instance
    check("sat0", 32'(ovr1), 32'd0);
    if1.req = 8'h0F;
    step();
    check("sat_p", 32'(if1.pend), 32'h0F);
    check("sat_c0", 32'(ovr1), 32'd0);
    if1.req = 8'h07;
    step();
    check("sat_c3", 32'(ovr1), 32'd3);
    check("sat_gi", 32'(if1.grant_idx), 32'd3);
    step();
    check("sat_hold1", 32'(ovr1), 32'd3);
    step();
    check("sat_hold2", 32'(ovr1), 32'd3);
    check("sat_pend", 32'(if1.pend), 32'h07);
    if1.req = 8'h00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
